instr_fetch: RTL and testbench

Sequencer that streams 32-bit rendering instructions from a synchronous program BRAM into the parser, one word per cycle. It sits directly upstream of the parser and drives its `instruction` / `valid_in` inputs. It pauses after each render instruction until the renderer signals completion, and absorbs downstream hold with a small buffer. It never mistakes the data word that follows a shape-set instruction for an opcode.

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 151 +++++++++++++++
 tb/tb_instr_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Handshake and bus bundle between instr_fetch and its surroundings
// (program BRAM port, parser stream, renderer completion, control/status).
interface instr_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] prog_last;
  logic                  hold;
  logic                  render_done;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [31:0]           bram_data;
  logic [31:0]           instruction;
  logic                  valid_out;
  logic                  busy;
  logic                  done;
  logic [15:0]           frame_count;

  modport master (
    input  start, prog_last, hold, render_done, bram_data,
    output bram_addr, instruction, valid_out, busy, done, frame_count
  );

  modport slave (
    output start, prog_last, hold, render_done, bram_data,
    input  bram_addr, instruction, valid_out, busy, done, frame_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Streams program words from a 2-cycle-latency BRAM into the parser, pausing after renders.
// Optional macro FETCH_LOOP_EN: wrap the program forever and count passes at emit time.
module instr_fetch #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);
  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;
  localparam logic [2:0]  OcFType  = 3'd1;
  localparam logic [2:0]  OcSeType = 3'd3;

  typedef enum logic [1:0] {StIdle, StFetch, StWaitRender, StDone} state_e;

  state_e                state_q;
  logic [31:0]           fifo_q [BUF_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic [1:0]            inflight_q;
  logic [ADDR_WIDTH-1:0] issue_ptr_q, last_q;
  logic                  issue_done_q, data_next_q;
`ifdef FETCH_LOOP_EN
  logic [ADDR_WIDTH-1:0] emit_ptr_q;
`else
  logic                  last_out, drained;
`endif

  logic            start_ok, can_issue, advance, pop, push, is_render;
  logic [OccW-1:0] occupancy;
  logic [31:0]     head;

  assign head      = fifo_q[rd_ptr_q];
  assign occupancy = {1'b0, count_q} + OccW'(inflight_q[0]) + OccW'(inflight_q[1]);
  // A start coinciding with the done pulse is dropped.
  assign start_ok  = (state_q == StIdle) && bus.start && !bus.done;
  assign can_issue = ((state_q == StFetch) || (state_q == StWaitRender)) && !issue_done_q &&
                     (occupancy < OccW'(BUF_DEPTH));
  assign advance   = (state_q == StFetch) || ((state_q == StWaitRender) && bus.render_done);
  assign pop       = advance && !bus.hold && (count_q != '0);
  assign push      = inflight_q[1];
  assign is_render = !data_next_q && (head[2:0] == OcFType) && (head[10:9] == 2'b00);
`ifndef FETCH_LOOP_EN
  assign last_out  = issue_done_q && (count_q == CntW'(1)) && (inflight_q == 2'b00);
  assign drained   = issue_done_q && (count_q == '0) && (inflight_q == 2'b00);
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.bram_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      inflight_q      <= '0;
      issue_ptr_q     <= '0;
      last_q          <= '0;
      issue_done_q    <= 1'b0;
      data_next_q     <= 1'b0;
      bus.bram_addr   <= '0;
      bus.instruction <= '0;
      bus.valid_out   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.frame_count <= '0;
`ifdef FETCH_LOOP_EN
      emit_ptr_q      <= '0;
`endif
    end else begin
      bus.done      <= 1'b0;
      bus.valid_out <= pop;
      inflight_q    <= {inflight_q[0], start_ok || can_issue};
      count_q       <= count_q + CntW'(push) - CntW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q        <= rd_ptr_q + PtrW'(1);
        bus.instruction <= head;
        // The word after a shape-set is data, never an opcode.
        if (data_next_q)                   data_next_q <= 1'b0;
        else if (head[2:0] == OcSeType)    data_next_q <= 1'b1;
      end

      if (start_ok) begin
        last_q        <= bus.prog_last;
        bus.bram_addr <= '0;
        issue_ptr_q   <= (bus.prog_last == '0) ? '0 : ADDR_WIDTH'(1);
`ifdef FETCH_LOOP_EN
        issue_done_q  <= 1'b0;
`else
        issue_done_q  <= (bus.prog_last == '0);
`endif
      end else if (can_issue) begin
        bus.bram_addr <= issue_ptr_q;
        if (issue_ptr_q == last_q) begin
          issue_ptr_q  <= '0;
`ifndef FETCH_LOOP_EN
          issue_done_q <= 1'b1;
`endif
        end else begin
          issue_ptr_q <= issue_ptr_q + ADDR_WIDTH'(1);
        end
      end

`ifdef FETCH_LOOP_EN
      if (pop) begin
        if (emit_ptr_q == last_q) begin
          emit_ptr_q      <= '0;
          bus.frame_count <= bus.frame_count + 16'd1;
        end else begin
          emit_ptr_q <= emit_ptr_q + ADDR_WIDTH'(1);
        end
      end
`endif

      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q     <= StFetch;
            bus.busy    <= 1'b1;
            data_next_q <= 1'b0;
`ifdef FETCH_LOOP_EN
            emit_ptr_q  <= '0;
`endif
          end
        end
        StFetch, StWaitRender: begin
          if (advance) begin
            if (pop && is_render) state_q <= StWaitRender;
`ifndef FETCH_LOOP_EN
            else if ((pop && last_out) || drained) state_q <= StDone;
`endif
            else state_q <= StFetch;
          end
        end
        StDone: begin
          state_q         <= StIdle;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          bus.frame_count <= bus.frame_count + 16'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch with a 2-cycle BRAM model and a
// stream/timing reference computed from the program contents.
module tb_instr_fetch;
  localparam int unsigned AW = 12;
  localparam logic [2:0] OcF = 3'd1, OcSe = 3'd3, OcCam = 3'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_WIDTH(AW)) bus ();
  instr_fetch #(.ADDR_WIDTH(AW), .BUF_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [0:4095];
  int cyc = 0, checks = 0, errors = 0, exp_frames = 0, hold_viol = 0;
  logic hold_prev = 1'b0;
  logic [31:0] got_w[$];
  int          got_t[$];
  logic [15:0] got_fc[$];
  int          done_t[$];
  logic        done_busy[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.bram_data <= mem[bus.bram_addr];

  // Times are recorded as the index of the edge at which the value is sampled.
  always @(negedge clk) begin
    if (bus.valid_out) begin
      got_w.push_back(bus.instruction);
      got_t.push_back(cyc + 1);
      got_fc.push_back(bus.frame_count);
      if (hold_prev) hold_viol++;
    end
    if (bus.done) begin
      done_t.push_back(cyc + 1);
      done_busy.push_back(bus.busy);
    end
    hold_prev = bus.hold;
  end

  function automatic logic [31:0] plain_word();
    logic [31:0] w = $urandom();
    w[2:0] = OcCam;
    return w;
  endfunction

  function automatic logic [31:0] other_word();
    logic [31:0] w = $urandom();
    if (w[2:0] == OcSe) w[2:0] = OcCam;
    if (w[2:0] == OcF && w[10:9] == 2'b00) w[9] = 1'b1;
    return w;
  endfunction

  function automatic logic [31:0] render_word();
    logic [31:0] w = $urandom();
    w[2:0]  = OcF;
    w[10:9] = 2'b00;
    return w;
  endfunction

  task automatic clear_mon();
    got_w.delete(); got_t.delete(); got_fc.delete(); done_t.delete(); done_busy.delete();
    hold_viol = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.start = 1'b0; bus.hold = 1'b0; bus.render_done = 1'b0; bus.prog_last = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    clear_mon();
    exp_frames = 0;
  endtask

  task automatic launch(input logic [AW-1:0] last, output int ts);
    bus.prog_last = last; bus.start = 1'b1;
    @(posedge clk); #1;
    ts = cyc; bus.start = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_render();
    bus.render_done = 1'b1; @(posedge clk); #1; bus.render_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (bus.bram_addr !== '0)   begin errors++; $display("FAIL reset_addr got %0h want 0", bus.bram_addr); end
    if (bus.instruction !== '0) begin errors++; $display("FAIL reset_instr got %0h want 0", bus.instruction); end
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid_out); end
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    if (bus.frame_count !== '0) begin errors++; $display("FAIL reset_frames got %0d want 0", bus.frame_count); end
    repeat (5) @(posedge clk);
    #1; checks++;
    if (got_w.size() != 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_quiet got words=%0d busy=%b want 0 0", got_w.size(), bus.busy);
    end
  endtask

  task automatic test_one_word();
    int ts;
    mem[0] = plain_word();
    clear_mon();
    launch('0, ts);
    wait_until(ts + 4);
    // This start lands on the done cycle and must be ignored.
    bus.start = 1'b1; @(posedge clk); #1; bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1; exp_frames++;
    checks++;
    if (got_w.size() != 1) begin errors++; $display("FAIL one_count got %0d want 1", got_w.size()); end
    else begin
      checks += 2;
      if (got_w[0] !== mem[0]) begin errors++; $display("FAIL one_word got %0h want %0h", got_w[0], mem[0]); end
      if (got_t[0] != ts + 4)  begin errors++; $display("FAIL one_time got %0d want %0d", got_t[0], ts + 4); end
    end
    checks++;
    if (done_t.size() != 1) begin errors++; $display("FAIL one_done_cnt got %0d want 1", done_t.size()); end
    else begin
      checks += 2;
      if (done_t[0] != ts + 5) begin errors++; $display("FAIL one_done_t got %0d want %0d", done_t[0], ts + 5); end
      if (done_busy[0] !== 1'b0) begin errors++; $display("FAIL one_busy_at_done got 1 want 0"); end
    end
    checks += 2;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_on_done busy got 1 want 0"); end
    if (bus.frame_count !== 16'(exp_frames)) begin
      errors++; $display("FAIL one_frames got %0d want %0d", bus.frame_count, exp_frames);
    end
  endtask

  task automatic test_render();
    int ts, r, exp;
    for (int i = 0; i < 8; i++) mem[i] = plain_word();
    mem[2] = render_word();
    clear_mon();
    launch(7, ts);
    wait_until(ts + 1); pulse_render();  // outside WAIT_RENDER
    wait_until(ts + 4); pulse_render();  // same cycle as the render word
    r = ts + 26;
    wait_until(r - 1); pulse_render();
    for (int i = 0; i < 40 && done_t.size() == 0; i++) begin @(posedge clk); #1; end
    exp_frames++;
    checks++;
    if (got_w.size() != 8) begin errors++; $display("FAIL render_count got %0d want 8", got_w.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        exp = (i <= 2) ? ts + 4 + i : r + 1 + (i - 3);
        checks += 2;
        if (got_w[i] !== mem[i]) begin errors++; $display("FAIL render_word%0d got %0h want %0h", i, got_w[i], mem[i]); end
        if (got_t[i] != exp) begin errors++; $display("FAIL render_time%0d got %0d want %0d", i, got_t[i], exp); end
      end
    end
    checks++;
    if (done_t.size() != 1 || done_t[0] != r + 6) begin
      errors++; $display("FAIL render_done got n=%0d want t=%0d", done_t.size(), r + 6);
    end
  endtask

  task automatic test_basic();
    int ts;
    for (int i = 0; i < 8; i++) mem[i] = plain_word();
    clear_mon();
    launch(7, ts);
    checks += 2;
    if (bus.bram_addr !== '0) begin errors++; $display("FAIL basic_addr0 got %0h want 0", bus.bram_addr); end
    if (bus.busy !== 1'b1)    begin errors++; $display("FAIL basic_busy got 0 want 1"); end
    for (int i = 0; i < 30 && done_t.size() == 0; i++) begin @(posedge clk); #1; end
    exp_frames++;
    checks++;
    if (got_w.size() != 8) begin errors++; $display("FAIL basic_count got %0d want 8", got_w.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks += 2;
        if (got_w[i] !== mem[i]) begin errors++; $display("FAIL basic_word%0d got %0h want %0h", i, got_w[i], mem[i]); end
        if (got_t[i] != ts + 4 + i) begin errors++; $display("FAIL basic_time%0d got %0d want %0d", i, got_t[i], ts + 4 + i); end
      end
    end
    checks += 2;
    if (done_t.size() != 1 || done_t[0] != ts + 12 || done_busy[0] !== 1'b0) begin
      errors++; $display("FAIL basic_done got n=%0d want t=%0d busy 0", done_t.size(), ts + 12);
    end
    if (bus.frame_count !== 16'(exp_frames)) begin
      errors++; $display("FAIL basic_frames got %0d want %0d", bus.frame_count, exp_frames);
    end
  endtask

  task automatic test_shape();
    int ts;
    mem[0] = plain_word();
    mem[1] = plain_word(); mem[1][2:0] = OcSe;
    mem[2] = render_word();                        // shape data, not a render
    mem[3] = plain_word();
    mem[4] = render_word(); mem[4][10:9] = 2'b01;  // F-type but not a render
    mem[5] = plain_word(); mem[5][2:0] = OcSe;
    mem[6] = plain_word(); mem[6][2:0] = OcSe;     // data: must not arm the flag again
    mem[7] = render_word();                        // a real render
    clear_mon();
    launch(7, ts);
    wait_until(ts + 14);
    checks += 2;
    if (done_t.size() != 0) begin errors++; $display("FAIL shape_early_done got %0d want 0", done_t.size()); end
    if (got_w.size() != 8) begin errors++; $display("FAIL shape_count got %0d want 8", got_w.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks += 2;
        if (got_w[i] !== mem[i]) begin errors++; $display("FAIL shape_word%0d got %0h want %0h", i, got_w[i], mem[i]); end
        if (got_t[i] != ts + 4 + i) begin errors++; $display("FAIL shape_time%0d got %0d want %0d", i, got_t[i], ts + 4 + i); end
      end
    end
    pulse_render();
    for (int i = 0; i < 10 && done_t.size() == 0; i++) begin @(posedge clk); #1; end
    exp_frames++;
    checks++;
    if (done_t.size() != 1) begin errors++; $display("FAIL shape_done got %0d want 1", done_t.size()); end
  endtask

  task automatic test_hold_random();
    int ts;
    for (int i = 0; i < 64; i++) mem[i] = other_word();
    clear_mon();
    launch(63, ts);
    for (int i = 0; i < 600 && done_t.size() == 0; i++) begin
      bus.hold = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.hold = 1'b0;
    exp_frames++;
    checks += 3;
    if (done_t.size() != 1) begin errors++; $display("FAIL hold_done got %0d want 1", done_t.size()); end
    if (hold_viol != 0) begin errors++; $display("FAIL hold_violation got %0d want 0", hold_viol); end
    if (got_w.size() != 64) begin errors++; $display("FAIL hold_count got %0d want 64", got_w.size()); end
    else begin
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (got_w[i] !== mem[i]) begin errors++; $display("FAIL hold_word%0d got %0h want %0h", i, got_w[i], mem[i]); end
      end
    end
    checks++;
    if (bus.frame_count !== 16'(exp_frames)) begin
      errors++; $display("FAIL hold_frames got %0d want %0d", bus.frame_count, exp_frames);
    end
  endtask

  task automatic test_reset_mid();
    int ts;
    for (int i = 0; i < 8; i++) mem[i] = plain_word();
    clear_mon();
    launch(7, ts);
    wait_until(ts + 5);
    rst = 1'b1; @(posedge clk); #1;
    exp_frames = 0;
    checks += 5;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid got 1 want 0"); end
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got 1 want 0"); end
    if (bus.bram_addr !== '0)   begin errors++; $display("FAIL midrst_addr got %0h want 0", bus.bram_addr); end
    if (bus.instruction !== '0) begin errors++; $display("FAIL midrst_instr got %0h want 0", bus.instruction); end
    if (bus.frame_count !== '0) begin errors++; $display("FAIL midrst_frames got %0d want 0", bus.frame_count); end
    rst = 1'b0;
    clear_mon();
    repeat (10) @(posedge clk);
    #1; checks++;
    if (got_w.size() != 0) begin errors++; $display("FAIL midrst_stale got %0d want 0", got_w.size()); end
    for (int i = 0; i < 8; i++) mem[i] = plain_word();
    launch(7, ts);
    for (int i = 0; i < 30 && done_t.size() == 0; i++) begin @(posedge clk); #1; end
    exp_frames++;
    checks++;
    if (got_w.size() != 8) begin errors++; $display("FAIL restart_count got %0d want 8", got_w.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks += 2;
        if (got_w[i] !== mem[i]) begin errors++; $display("FAIL restart_word%0d got %0h want %0h", i, got_w[i], mem[i]); end
        if (got_t[i] != ts + 4 + i) begin errors++; $display("FAIL restart_time%0d got %0d want %0d", i, got_t[i], ts + 4 + i); end
      end
    end
    checks++;
    if (bus.frame_count !== 16'(exp_frames)) begin
      errors++; $display("FAIL restart_frames got %0d want %0d", bus.frame_count, exp_frames);
    end
  endtask

  task automatic test_loop();
    int ts;
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = plain_word();
    launch(3, ts);
    for (int i = 0; i < 60 && got_w.size() < 14; i++) begin @(posedge clk); #1; end
    checks++;
    if (got_w.size() < 14) begin errors++; $display("FAIL loop_count got %0d want 14", got_w.size()); end
    else begin
      for (int i = 0; i < 14; i++) begin
        checks += 3;
        if (got_w[i] !== mem[i % 4]) begin errors++; $display("FAIL loop_word%0d got %0h want %0h", i, got_w[i], mem[i % 4]); end
        if (got_t[i] != ts + 4 + i) begin errors++; $display("FAIL loop_time%0d got %0d want %0d", i, got_t[i], ts + 4 + i); end
        if (got_fc[i] !== 16'((i + 1) / 4)) begin
          errors++; $display("FAIL loop_frames%0d got %0d want %0d", i, got_fc[i], (i + 1) / 4);
        end
      end
    end
    checks++;
    if (done_t.size() != 0) begin errors++; $display("FAIL loop_done got %0d want 0", done_t.size()); end
    do_reset();
  endtask

  initial begin
    bus.start = 1'b0; bus.hold = 1'b0; bus.render_done = 1'b0; bus.prog_last = '0;
    test_reset();
`ifdef FETCH_LOOP_EN
    test_loop();
`else
    test_one_word();
    test_render();
    test_basic();
    test_shape();
    test_hold_random();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
